// File: rtl/mux8_rr_arbiter.sv
// Purpose: round-robin / fixed-priority 8:1 arbiter that owns the shared mux select and registers the winner's data.
// Latency: one cycle from the ack edge to dout; one word per cycle is sustained while dout_ready stays high.
// Backpressure: while dout_valid && !dout_ready everything holds and ack stays low; there is no skid buffer.
module mux8_rr_arbiter #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        req,
    input  logic [8*DW-1:0]   din,
    input  logic [7:0]        mask,
    input  logic              mode,
    output logic [7:0]        ack,
    output logic [2:0]        sel,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  ptr;
    logic [7:0]  elig;
    logic        load;
    logic        found;
    logic [2:0]  win;
    logic [2:0]  idx;

    assign elig       = req & mask;
    assign dout_valid = (state_q == FULL);
    assign load       = (|elig) && (!dout_valid || dout_ready);

    // Winner search: scan from ptr (round-robin) or from index 0 (fixed priority).
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = (mode ? 3'd0 : ptr) + 3'(k);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Grant is combinational; held low during reset so nothing is acknowledged while state is being cleared.
    always_comb begin
        ack = 8'd0;
        if (rst_n && load) begin
            ack = 8'b1 << win;
        end
    end

    // Next-state: FULL whenever a word is loaded, EMPTY only when the held word drains with nothing behind it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!load && dout_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: capture winner's slice, remember it in sel, and advance the rotation pointer past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            sel  <= 3'd0;
            ptr  <= 3'd0;
        end else if (load) begin
            dout <= din[win*DW +: DW];
            sel  <= win;
            ptr  <= win + 3'd1;
        end
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Shares one registered 8:1 data path between eight independent requesters. Each cycle it picks one requester by round-robin (or fixed priority), steers that requester's data through the 8:1 select into an output register, and hands it downstream with a valid/ready handshake. The block sits directly in front of the shared mux consumer and owns the mux select.

## Interface
- DW, 8, data width per requester
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  per-requester valid; requester i holds req[i] and its din slice until ack[i]
- din  input  8*DW  packed requester data; slice i = din[i*DW +: DW]
- mask  input  8  per-requester enable; masked requesters are never granted
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- ack  output  8  one-hot or zero, combinational; ack[i]=1 means din slice i is captured at this edge
- sel  output  3  index of the most recently granted requester (registered)
- dout  output  DW  registered output data
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  downstream accepts dout when dout_valid && dout_ready

## Operation
- Eligible vector: elig = req & mask.
- Load condition: load = (|elig) && (!dout_valid || dout_ready).
- Winner g when load:
  - mode=0: first set bit of elig scanning ptr, ptr+1, ... ptr+7 (mod 8).
  - mode=1: lowest set bit of elig; ptr ignored for selection.
- On load: dout <= din slice g, dout_valid <= 1, sel <= g, ptr <= (g+1) mod 8 (also updated in mode=1), ack[g]=1 this cycle.
- Output accepted and !load (dout_valid && dout_ready && elig==0): dout_valid <= 0; dout, sel, ptr unchanged.
- Stall (dout_valid && !dout_ready): dout, dout_valid, sel, ptr held; ack=0 regardless of req.
- Two-state FSM equivalent to dout_valid: EMPTY (0) and FULL (1). EMPTY->FULL on load; FULL->FULL on stall or accept-with-load; FULL->EMPTY on accept without load.
- ptr is 3 bits, wraps 7->0 naturally.
- mask or mode changes take effect on the next arbitration only; a word already in dout is never altered.
- A requester that drops req before ack loses its turn with no side effect; ptr does not move.

## Timing
- Reset values (async, immediate on rst_n=0): dout=0, dout_valid=0, sel=0, ptr=0; ack forced to 0 while rst_n=0.
- ack is combinational from req, mask, mode, ptr, dout_valid, dout_ready; no combinational path from din to any output.
- Latency: data captured at the edge where ack[g]=1 appears on dout the following cycle with dout_valid=1.
- Throughput: one word per cycle while dout_ready=1 and elig!=0.
- Fairness (mode=0): with all eight continuously requesting and dout_ready=1, every requester is granted exactly once in any 8 consecutive grants.
- Reset mid-operation: pending dout word is discarded, no ack issued during reset; first arbitration after release starts from ptr=0.

## Test plan
- Reset: rst_n=0 with req=8'hFF, mask=8'hFF -> ack=0, dout=0, dout_valid=0, sel=0; release -> first edge grants requester 0.
- Full round-robin: mode=0, req=mask=8'hFF, din slice i = i*8'h11, dout_ready=1 -> ack walks 0,1,...,7,0 on consecutive cycles; dout shows 8'h00,8'h11,...,8'h77 one cycle after each ack.
- Backpressure: after first capture (dout=8'h00) hold dout_ready=0 for 4 cycles -> dout stays 8'h00, dout_valid=1, ack=0 throughout; raise dout_ready -> ack[1] same cycle, dout=8'h11 next cycle.
- Wrap and skip: after a grant to 6 set req=8'b1000_0010 -> grants 7 then 1; then req=0 with dout_ready=1 -> dout_valid falls to 0, sel stays 1.
- Mask and fixed priority: mode=1, req=8'b1010_0100, mask=8'hFB -> grant 5 every cycle; set mask=8'hFF -> grant 2 on next arbitration.
- Reset mid-stall: dout_valid=1, dout_ready=0, pull rst_n low mid-cycle -> dout_valid=0 and dout=0 without waiting for clk; after release with req=8'h80 -> grant 7 (scan from ptr=0).
